// File: rtl/msmouse_serial_rx.sv
// Microsoft serial mouse receiver: 7N1-style byte deserializer, 'M' ident detection
// after an RTS rising edge, and 3-byte packet assembly into buttons and signed motion.
module msmouse_serial_rx #(
  parameter int unsigned CLKFREQ = 50_000_000,
  parameter int unsigned BAUD    = 1_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rts,
  output logic       pkt_valid,
  output logic       lbut,
  output logic       rbut,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       ident_valid,
  output logic       frame_err
);

  localparam int unsigned BITPERIOD = CLKFREQ / BAUD;
  localparam int unsigned HALFBIT   = BITPERIOD / 2;
  localparam int unsigned CNT_W     = (BITPERIOD > 2) ? $clog2(BITPERIOD) : 1;
  // Counter fires on reaching zero, so reload with period-1 for exact spacing.
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BITPERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALFBIT - 1);
  localparam logic [6:0]       IDENT_BYTE  = 7'h4D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAITHIGH
  } state_t;

  logic [1:0]       rxd_sync_q;
  logic [1:0]       rts_sync_q;
  logic             rxd_prev_q;
  logic             rts_prev_q;
  logic [1:0]       settle_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [6:0]       shift_q;
  logic [1:0]       pkt_idx_q;
  logic [5:0]       b0_q;
  logic [5:0]       b1_q;
  logic             ident_armed_q;

  logic rxd_s;
  logic rxd_fall;
  logic rts_rise;
  logic cnt_zero;
  logic byte_done;
  logic frame_bad;

  assign rxd_s     = rxd_sync_q[1];
  assign rxd_fall  = rxd_prev_q & ~rxd_s;
  assign rts_rise  = rts_sync_q[1] & ~rts_prev_q;
  assign cnt_zero  = (cnt_q == '0);
  assign byte_done = ~rts_rise & (state_q == ST_STOP) & cnt_zero & rxd_s;
  assign frame_bad = ~rts_rise & (state_q == ST_STOP) & cnt_zero & ~rxd_s;

  // Synchronizers and edge detectors; rxd edge history is held low until the
  // synchronizer has flushed its reset value, so a line low at reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_sync_q <= 2'b11;
      rts_sync_q <= 2'b00;
      rxd_prev_q <= 1'b0;
      rts_prev_q <= 1'b0;
      settle_q   <= 2'd0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[0], rxd};
      rts_sync_q <= {rts_sync_q[0], rts};
      rts_prev_q <= rts_sync_q[1];
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end else begin
        rxd_prev_q <= rxd_s;
      end
    end
  end

  // Bit-level receive FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 7'd0;
    end else if (rts_rise) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rxd_fall) begin
            cnt_q   <= HALF_RELOAD;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rxd_s) begin
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= 3'd0;
            state_q   <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q <= {rxd_s, shift_q[6:1]};
            cnt_q   <= BIT_RELOAD;
            if (bit_idx_q == 3'd6) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rxd_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAITHIGH;
          end
        end
        ST_WAITHIGH: begin
          if (rxd_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ident detection and packet assembly; strobes land one clk after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_idx_q     <= 2'd0;
      b0_q          <= 6'd0;
      b1_q          <= 6'd0;
      ident_armed_q <= 1'b0;
      pkt_valid     <= 1'b0;
      ident_valid   <= 1'b0;
      frame_err     <= 1'b0;
      lbut          <= 1'b0;
      rbut          <= 1'b0;
      dx            <= 8'h00;
      dy            <= 8'h00;
    end else begin
      pkt_valid   <= 1'b0;
      ident_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (rts_rise) begin
        pkt_idx_q     <= 2'd0;
        ident_armed_q <= 1'b1;
      end else if (frame_bad) begin
        frame_err <= 1'b1;
        pkt_idx_q <= 2'd0;
      end else if (byte_done) begin
        ident_armed_q <= 1'b0;
        if (ident_armed_q && (shift_q == IDENT_BYTE)) begin
          ident_valid <= 1'b1;
        end else if (shift_q[6]) begin
          b0_q      <= shift_q[5:0];
          pkt_idx_q <= 2'd1;
        end else begin
          case (pkt_idx_q)
            2'd1: begin
              b1_q      <= shift_q[5:0];
              pkt_idx_q <= 2'd2;
            end
            2'd2: begin
              pkt_idx_q <= 2'd0;
              pkt_valid <= 1'b1;
              lbut      <= b0_q[5];
              rbut      <= b0_q[4];
              dx        <= {b0_q[1:0], b1_q};
              dy        <= {b0_q[3:2], shift_q[5:0]};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_msmouse_serial_rx.sv
// Directed bench for msmouse_serial_rx: serial byte stimulus at a short bit period,
// strobe counting monitor and hand-computed packet expectations.
module tb_msmouse_serial_rx;

  localparam int unsigned CLKFREQ = 24_000;
  localparam int unsigned BAUD    = 1_200;
  localparam int unsigned BP      = CLKFREQ / BAUD;
  localparam int unsigned HB      = BP / 2;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic       rts;
  logic       pkt_valid;
  logic       lbut;
  logic       rbut;
  logic [7:0] dx;
  logic [7:0] dy;
  logic       ident_valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_pkt  = 0;
  int n_id   = 0;
  int n_fe   = 0;
  int pkt_cyc  = 0;
  int fall_cyc = 0;
  int b_pkt, b_id, b_fe;
  int lat;

  msmouse_serial_rx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rts         (rts),
    .pkt_valid   (pkt_valid),
    .lbut        (lbut),
    .rbut        (rbut),
    .dx          (dx),
    .dy          (dy),
    .ident_valid (ident_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (pkt_valid) begin
      n_pkt   = n_pkt + 1;
      pkt_cyc = cyc;
    end
    if (ident_valid) n_id = n_id + 1;
    if (frame_err)   n_fe = n_fe + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    idle(BP);
  endtask

  // Start bit, 8 data bits LSB first, stop bit.
  task automatic send_byte(input logic [7:0] b);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  task automatic snap();
    b_pkt = n_pkt;
    b_id  = n_id;
    b_fe  = n_fe;
  endtask

  task automatic check_pkt(input string tag, input int npkt, input logic l, input logic r,
                           input logic [7:0] ex, input logic [7:0] ey);
    check_eq({tag, "_count"}, 32'(n_pkt - b_pkt), 32'(npkt));
    check_eq({tag, "_lbut"},  32'(lbut), 32'(l));
    check_eq({tag, "_rbut"},  32'(rbut), 32'(r));
    check_eq({tag, "_dx"},    32'(dx), 32'(ex));
    check_eq({tag, "_dy"},    32'(dy), 32'(ey));
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    rts   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_strobes", 32'({pkt_valid, ident_valid, frame_err}), 32'd0);
    check_eq("rst_btn_dx_dy", 32'({lbut, rbut, dx, dy}), 32'd0);
    reset = 1'b0;
    idle(5);

    // Basic packet 0x6C 0x05 0x3D
    snap();
    send_byte(8'hEC);
    send_byte(8'h85);
    send_byte(8'hBD);
    lat = pkt_cyc - fall_cyc;
    check_pkt("basic", 1, 1'b1, 1'b0, 8'h05, 8'hFD);
    check_eq("basic_latency", 32'((lat >= int'(8 * BP + HB)) && (lat <= int'(8 * BP + HB + 6))), 32'd1);
    check_eq("basic_no_ferr", 32'(n_fe - b_fe), 32'd0);
    idle(3 * BP);
    check_eq("hold_dx_dy", 32'({lbut, rbut, dx, dy}), 32'({1'b1, 1'b0, 8'h05, 8'hFD}));

    // RTS re-identification followed by a normal packet
    snap();
    rts = 1'b1;
    idle(10);
    send_byte(8'hCD);
    check_eq("ident_count", 32'(n_id - b_id), 32'd1);
    check_eq("ident_no_pkt", 32'(n_pkt - b_pkt), 32'd0);
    send_byte(8'hEC);
    send_byte(8'h85);
    send_byte(8'hBD);
    check_pkt("post_ident", 1, 1'b1, 1'b0, 8'h05, 8'hFD);
    check_eq("post_ident_id", 32'(n_id - b_id), 32'd1);

    // Armed only for the first byte: a later 'M' is a sync byte
    rts = 1'b0;
    idle(10);
    snap();
    rts = 1'b1;
    idle(10);
    send_byte(8'hEC);
    send_byte(8'hCD);
    send_byte(8'h85);
    send_byte(8'hBD);
    check_pkt("late_m", 1, 1'b0, 1'b0, 8'h45, 8'hFD);
    check_eq("late_m_no_ident", 32'(n_id - b_id), 32'd0);
    rts = 1'b0;
    idle(10);

    // Mid-packet resync on a second sync byte
    snap();
    send_byte(8'hEC);
    send_byte(8'h85);
    send_byte(8'hF0);
    send_byte(8'hBF);
    send_byte(8'h81);
    check_pkt("resync", 1, 1'b1, 1'b1, 8'h3F, 8'h01);

    // Frame error clears the packet index
    snap();
    send_byte(8'hEC);
    send_byte(8'h05);
    check_eq("ferr_count", 32'(n_fe - b_fe), 32'd1);
    send_byte(8'h85);
    send_byte(8'hBD);
    check_eq("ferr_no_pkt", 32'(n_pkt - b_pkt), 32'd0);
    send_byte(8'hEC);
    send_byte(8'h85);
    send_byte(8'hBD);
    check_pkt("after_ferr", 1, 1'b1, 1'b0, 8'h05, 8'hFD);
    check_eq("ferr_once", 32'(n_fe - b_fe), 32'd1);

    // Short low glitch is rejected
    snap();
    rxd = 1'b0;
    idle(HB / 2);
    rxd = 1'b1;
    idle(3 * BP);
    check_eq("glitch_strobes", 32'((n_pkt - b_pkt) + (n_id - b_id) + (n_fe - b_fe)), 32'd0);
    send_byte(8'hF0);
    send_byte(8'hBF);
    send_byte(8'h81);
    check_pkt("after_glitch", 1, 1'b1, 1'b1, 8'h3F, 8'h01);

    // Reset mid-byte with the line held low across release
    snap();
    rxd = 1'b0;
    idle(BP + HB);
    reset = 1'b1;
    idle(3);
    check_eq("midrst_outputs", 32'({pkt_valid, ident_valid, frame_err, lbut, rbut, dx, dy}), 32'd0);
    reset = 1'b0;
    idle(3 * BP);
    check_eq("low_after_rst", 32'((n_pkt - b_pkt) + (n_id - b_id) + (n_fe - b_fe)), 32'd0);
    rxd = 1'b1;
    idle(BP);
    send_byte(8'hEC);
    send_byte(8'h85);
    send_byte(8'hBD);
    check_pkt("after_rst", 1, 1'b1, 1'b0, 8'h05, 8'hFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msmouse_serial_rx.md
MSMOUSE_SERIAL_RX -- requirements
Module: msmouse_serial_rx

Interface
REQ-001 Parameter CLKFREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 1_200, serial bit rate. BITPERIOD = CLKFREQ/BAUD (41666 at defaults); HALFBIT = BITPERIOD/2 (20833).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  1  Microsoft-mouse serial line, asynchronous to clk, idle high.
REQ-006 rts  input  1  host RTS level, asynchronous to clk; a rising edge requests mouse re-identification.
REQ-007 pkt_valid  output  1  one-cycle strobe; lbut/rbut/dx/dy are updated in the same cycle.
REQ-008 lbut, rbut  output  1 each  left and right button state from the last packet.
REQ-009 dx, dy  output  8 each  signed two's-complement motion from the last packet.
REQ-010 ident_valid  output  1  one-cycle strobe when the 'M' identification byte (0x4D) is received.
REQ-011 frame_err  output  1  one-cycle strobe on stop-bit error.

Function
REQ-012 rxd and rts each SHALL pass through a 2-flop synchronizer; all later logic SHALL use the synchronized versions only.
REQ-013 The bit FSM SHALL have states IDLE, START, DATA, STOP and WAITHIGH, with a BITPERIOD-range down-counter of $clog2(BITPERIOD) bits.
REQ-014 IDLE: a synchronized rxd 1->0 transition SHALL load HALFBIT and enter START.
REQ-015 START: at counter 0, rxd=0 SHALL load BITPERIOD and enter DATA; rxd=1 is a glitch and SHALL return to IDLE with no strobe.
REQ-016 DATA: 7 bits SHALL be sampled, LSB first, one every BITPERIOD at bit centre, then the FSM SHALL enter STOP.
REQ-017 STOP: at counter 0, rxd=1 SHALL complete the 7-bit byte and return to IDLE (a following high bit, such as an 8th data bit of 1, is treated as idle); rxd=0 SHALL pulse frame_err, clear the packet index, and enter WAITHIGH.
REQ-018 WAITHIGH SHALL stay until synchronized rxd=1, then enter IDLE.
REQ-019 A synchronized rts rising edge SHALL do all of the following in the same cycle:
  - abort any receive in progress and force IDLE;
  - clear the packet index;
  - set ident_armed.
REQ-020 For the first completed byte while ident_armed=1, ident_armed SHALL clear.
  - If that byte equals 0x4D, ident_valid SHALL pulse and the byte SHALL NOT enter the assembler.
  - Otherwise the byte SHALL be processed normally.
REQ-021 The assembler holds index 0..2 and registers b0, b1. A byte with bit6=1 SHALL always be stored as b0 and set index to 1, including mid-packet resync.
REQ-022 A bit6=0 byte at index 0 SHALL be discarded; at index 1 it SHALL be stored as b1 and set index to 2.
REQ-023 A bit6=0 byte at index 2 (b2) SHALL complete the packet: set index to 0 and, in the same cycle, pulse pkt_valid with:
  - lbut=b0[5], rbut=b0[4];
  - dx={b0[1:0],b1[5:0]}, dy={b0[3:2],b2[5:0]}.
REQ-024 Strobe latency SHALL be one clk after the stop-bit sample cycle.
REQ-025 If a new byte completes in the same cycle as an rts edge, the rts edge SHALL win and the byte SHALL be dropped.
REQ-026 Outputs SHALL hold their values between pkt_valid strobes.

Reset
REQ-027 reset SHALL asynchronously force:
  - FSM to IDLE, counter 0, packet index 0, ident_armed 0;
  - synchronizer flops to 1 for rxd and 0 for rts;
  - all strobes 0; lbut, rbut 0; dx, dy 0x00.
REQ-028 After reset deasserts, a line already low SHALL NOT start a frame until a 1->0 edge is seen.

Verification
REQ-029 Send bytes 0x6C, 0x05, 0x3D at 1200 baud (8N1 with bit7=1) -> one pkt_valid with lbut=1, rbut=0, dx=0x05, dy=0xFD, one clk after the 3rd stop sample.
REQ-030 Raise rts, then send 0x4D -> ident_valid pulses once and pkt_valid stays 0; then send 0x6C, 0x05, 0x3D -> normal packet as in REQ-029.
REQ-031 Send 0x6C, 0x05, then 0x70, 0x3F, 0x01 -> exactly one pkt_valid with lbut=1, rbut=1, dx=0x3F, dy=0x01 (resync on the second sync byte).
REQ-032 Hold rxd low through the stop-bit position of the 2nd byte -> frame_err pulses once and no pkt_valid; a subsequent valid 3-byte packet decodes correctly.
REQ-033 Apply a rxd low glitch shorter than HALFBIT -> no strobes and the FSM returns to IDLE.
REQ-034 Assert reset mid-byte and release it -> all outputs 0, and the next clean packet decodes correctly.
